// File: rtl/rsa_exp_ctrl_if.sv
// Job request, mod_exp launch/operand and response signals of rsa_exp_ctrl.
// slave is the controller side; master is the host plus mod_exp side.
interface rsa_exp_ctrl_if #(
    parameter int DATA_WIDTH = 9
);
    localparam int TW = $clog2(DATA_WIDTH);

    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_c;
    logic [DATA_WIDTH-1:0] req_d;
    logic [DATA_WIDTH-1:0] req_n;

    logic                  me_start;
    logic [DATA_WIDTH-1:0] me_c;
    logic [DATA_WIDTH-1:0] me_d;
    logic [DATA_WIDTH-1:0] me_n;
    logic [DATA_WIDTH-1:0] me_r2_mod_n;
    logic [TW-1:0]         me_t_sub_1;
    logic                  me_ready;
    logic [DATA_WIDTH-1:0] me_m;
    logic                  me_done;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_m;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_c, req_d, req_n,
        input  me_ready, me_m, me_done,
        input  rsp_ready,
        output req_ready,
        output me_start, me_c, me_d, me_n, me_r2_mod_n, me_t_sub_1,
        output rsp_valid, rsp_m, rsp_err
    );

    modport master (
        output req_valid, req_c, req_d, req_n,
        output me_ready, me_m, me_done,
        output rsp_ready,
        input  req_ready,
        input  me_start, me_c, me_d, me_n, me_r2_mod_n, me_t_sub_1,
        input  rsp_valid, rsp_m, rsp_err
    );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// Sequences one mod_exp job: validates (c,d,n), derives t_sub_1 and 2^(2K) mod n by
// 2K shift-subtract steps, launches mod_exp and holds the result until rsp is taken.
module rsa_exp_ctrl #(
    parameter int DATA_WIDTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    rsa_exp_ctrl_if.slave     bus
);
    localparam int K    = DATA_WIDTH + 2;
    localparam int ITER = 2 * K;
    localparam int CW   = $clog2(ITER + 1);
    localparam int TW   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R2     = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] c_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0] n_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] rsp_m_q;
    logic                  rsp_err_q;
    logic [TW-1:0]         tsub_q;
    logic [CW-1:0]         cnt_q;

    function automatic logic [TW-1:0] msb_index(input logic [DATA_WIDTH-1:0] v);
        logic [TW-1:0] idx;
        idx = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (v[i]) idx = TW'(i);
        end
        return idx;
    endfunction

    logic req_bad;
    logic last_iter;
    logic [DATA_WIDTH:0]   x2;
    logic [DATA_WIDTH:0]   x2_sub;
    logic [DATA_WIDTH-1:0] x_d;

    // Even, tiny or non-reduced operands cannot go through Montgomery reduction.
    assign req_bad = !bus.req_n[0]
                   || (bus.req_n < DATA_WIDTH'(3))
                   || (bus.req_c >= bus.req_n);

    assign last_iter = (cnt_q == CW'(ITER - 1));

    // One doubling mod n per step; x < n keeps x2 within DATA_WIDTH+1 bits.
    always_comb begin
        x2     = {x_q, 1'b0};
        x2_sub = x2 - {1'b0, n_q};
        x_d    = x2[DATA_WIDTH-1:0];
        if (x2 >= {1'b0, n_q}) begin
            x_d = x2_sub[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            x_q       <= '0;
            rsp_m_q   <= '0;
            rsp_err_q <= 1'b0;
            tsub_q    <= '0;
            cnt_q     <= '0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        c_q    <= bus.req_c;
                        d_q    <= bus.req_d;
                        n_q    <= bus.req_n;
                        tsub_q <= msb_index(bus.req_d);
                        if (req_bad) begin
                            rsp_err_q <= 1'b1;
                            rsp_m_q   <= '0;
                            state_q   <= RESP;
                        end else if (bus.req_d == '0) begin
                            rsp_err_q <= 1'b0;
                            rsp_m_q   <= DATA_WIDTH'(1);
                            state_q   <= RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            x_q       <= DATA_WIDTH'(1);
                            cnt_q     <= '0;
                            state_q   <= R2;
                        end
                    end
                end
                R2: begin
                    x_q   <= x_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) state_q <= LAUNCH;
                end
                LAUNCH: begin
                    if (bus.me_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.me_done) begin
                        rsp_m_q   <= bus.me_m;
                        rsp_err_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Start is decoded in-cycle so a stalled (ce low) LAUNCH cycle neither fires nor loses it.
    assign bus.me_start    = (state_q == LAUNCH) && bus.me_ready && ce;
    assign bus.req_ready   = (state_q == IDLE) && !rst;
    assign bus.me_c        = c_q;
    assign bus.me_d        = d_q;
    assign bus.me_n        = n_q;
    assign bus.me_r2_mod_n = x_q;
    assign bus.me_t_sub_1  = tsub_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_m       = rsp_m_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Table-driven bench for rsa_exp_ctrl with a behavioural mod_exp and a response scoreboard.
module tb_rsa_exp_ctrl;
    localparam int DW = 9;
    localparam int K  = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b1;

    rsa_exp_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    rsa_exp_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c, d, n;
        int m, err, tsub, r2;
        int ce_low, rdy, hold, pre;
    } vec_t;

    typedef struct {
        int m;
        int err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   starts   = 0;

    always @(negedge clk) if (bus.me_start) starts++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int modexp(input int c, input int d, input int n);
        longint r = 1;
        longint b = c % n;
        int     e = d;
        while (e > 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return int'(r);
    endfunction

    task automatic reset_check(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_err"},   bus.rsp_err,   0);
        check({tag, "_rsp_m"},     bus.rsp_m,     0);
        check({tag, "_me_start"},  bus.me_start,  0);
        check({tag, "_me_c"},      bus.me_c,      0);
        check({tag, "_me_r2"},     bus.me_r2_mod_n, 0);
        check({tag, "_me_tsub"},   bus.me_t_sub_1, 0);
        tick();
        rst = 1'b0;
        #1;
        check({tag, "_req_ready"}, bus.req_ready, 1);
    endtask

    task automatic send_req(input int c, input int d, input int n, output bit ok);
        bus.req_c     = c[DW-1:0];
        bus.req_d     = d[DW-1:0];
        bus.req_n     = n[DW-1:0];
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
        ok = bus.req_ready;
        check("req_ready_wait", bus.req_ready, 1);
        if (ok) tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit   ok;
        int   s0;
        int   start_cyc;
        int   exp_start;
        int   mr;
        exp_t e;
        bus.rsp_ready = v.pre[0];
        bus.me_ready  = 1'b0;
        send_req(v.c, v.d, v.n, ok);
        if (!ok) return;
        sb.push_back('{v.m, v.err});
        s0 = starts;
        check("req_ready_busy", bus.req_ready, 0);
        if (v.err != 0 || v.d == 0) begin
            check("fast_rsp_valid", bus.rsp_valid, 1);
        end else begin
            exp_start = 2 * K + 1 + v.ce_low + v.rdy;
            start_cyc = -1;
            for (int cyc = 1; cyc < 200 && start_cyc < 0; cyc++) begin
                ce           = !(cyc >= 4 && cyc < 4 + v.ce_low);
                bus.me_ready = (cyc >= exp_start);
                #1;
                if (bus.me_start) start_cyc = cyc;
                else tick();
            end
            ce = 1'b1;
            check("start_cycle", start_cyc, exp_start);
            if (start_cyc < 0) begin
                reset_check("recover");
                sb.delete();
                return;
            end
            check("me_r2_mod_n", bus.me_r2_mod_n, v.r2);
            check("me_t_sub_1",  bus.me_t_sub_1,  v.tsub);
            check("me_c",        bus.me_c,        v.c);
            check("me_d",        bus.me_d,        v.d);
            check("me_n",        bus.me_n,        v.n);
            tick();
            bus.me_ready = 1'b0;
            check("start_one_cycle", bus.me_start, 0);
            repeat (3) tick();
            check("r2_stable_wait", bus.me_r2_mod_n, v.r2);
            check("rsp_valid_early", bus.rsp_valid, 0);
            mr          = modexp(v.c, v.d, v.n);
            bus.me_m    = mr[DW-1:0];
            bus.me_done = 1'b1;
            tick();
            bus.me_done  = 1'b0;
            bus.me_ready = 1'b1;
            check("rsp_valid_after_done", bus.rsp_valid, 1);
        end
        for (int i = 0; i < v.hold; i++) begin
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_m",     bus.rsp_m,     v.m);
            check("hold_rsp_err",   bus.rsp_err,   v.err);
            check("hold_req_ready", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        e = sb.pop_front();
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_m",     bus.rsp_m,     e.m);
        check("rsp_err",   bus.rsp_err,   e.err);
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("req_ready_back", bus.req_ready, 1);
        check("start_count", starts - s0, (v.err != 0 || v.d == 0) ? 0 : 1);
    endtask

    initial begin
        bit   ok;
        vec_t v;
        bus.req_valid = 1'b0;
        bus.req_c     = '0;
        bus.req_d     = '0;
        bus.req_n     = '0;
        bus.me_ready  = 1'b0;
        bus.me_m      = '0;
        bus.me_done   = 1'b0;
        bus.rsp_ready = 1'b0;

        //             c    d    n    m  err tsub r2 ceL rdy hold pre
        vecs.push_back('{255,   4, 511,  32, 0, 2,  16, 0, 0,  0, 0});
        vecs.push_back('{ 56,   5, 509, 393, 0, 2, 144, 0, 0,  0, 0});
        vecs.push_back('{ 56,   1, 509,  56, 0, 0, 144, 0, 0,  0, 0});
        vecs.push_back('{ 45,   5, 225,   0, 0, 2,  79, 0, 0,  0, 0});
        vecs.push_back('{  5,   3, 510,   0, 1, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{300,   3, 299,   0, 1, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{  0,   3,   1,   0, 1, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{  7,   0, 509,   1, 0, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{509,   3, 509,   0, 1, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{  3,   0,   4,   0, 1, 0,   0, 0, 0,  0, 0});
        vecs.push_back('{  2,   3,   3,   2, 0, 1,   1, 0, 0,  0, 0});
        vecs.push_back('{510, 256, 511,   1, 0, 8,  16, 0, 0,  0, 1});
        vecs.push_back('{ 56,   5, 509, 393, 0, 2, 144, 0, 0, 10, 0});
        vecs.push_back('{255,   4, 511,  32, 0, 2,  16, 0, 5,  0, 0});
        vecs.push_back('{ 45,   5, 225,   0, 0, 2,  79, 3, 0,  0, 0});
        vecs.push_back('{  5,   3, 510,   0, 1, 0,   0, 0, 0,  0, 1});
        vecs.push_back('{  7,   0, 509,   1, 0, 0,   0, 0, 0,  3, 0});

        #2;
        reset_check("por");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of R2, then a stray done while idle.
        bus.me_ready = 1'b0;
        send_req(56, 5, 509, ok);
        repeat (8) tick();
        check("r2_busy_req_ready", bus.req_ready, 0);
        reset_check("rst_r2");
        bus.me_m    = 9'd77;
        bus.me_done = 1'b1;
        tick();
        bus.me_done = 1'b0;
        tick();
        check("stray_done_rsp_valid", bus.rsp_valid, 0);
        check("stray_done_req_ready", bus.req_ready, 1);

        // Reset while waiting on mod_exp, then a stray done, then a clean job.
        bus.me_ready = 1'b1;
        send_req(255, 4, 511, ok);
        for (int i = 0; i < 40 && !bus.me_start; i++) tick();
        check("wait_path_start", bus.me_start, 1);
        tick();
        tick();
        reset_check("rst_wait");
        bus.me_m    = 9'd32;
        bus.me_done = 1'b1;
        tick();
        bus.me_done = 1'b0;
        tick();
        check("stray_done2_rsp_valid", bus.rsp_valid, 0);
        check("stray_done2_rsp_m",     bus.rsp_m,     0);
        v = vecs[1];
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Request-side sequencer for the `mod_exp` core. It accepts an exponentiation job (c, d, n) over a valid/ready handshake and derives the Montgomery operands `mod_exp` needs: t_sub_1 (MSB index of d) and r2_mod_n = 2^(2K) mod n with K = DATA_WIDTH+2. It then issues a `start` pulse to `mod_exp`, waits for `done`, and returns m = c^d mod n on a valid/ready response port. It sits between the RSA host/bus logic and a single `mod_exp` instance.

## Interface
- DATA_WIDTH, 9, operand width; must equal the `mod_exp` instance's DATA_WIDTH; K = DATA_WIDTH+2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low, all registers hold.
- req_valid  in  1  job offered.
- req_ready  out  1  high only in IDLE.
- req_c, req_d, req_n  in  DATA_WIDTH each  base, exponent, modulus.
- me_start  out  1  one-cycle start pulse to `mod_exp`.
- me_c, me_d, me_n, me_r2_mod_n  out  DATA_WIDTH each  operands to `mod_exp`.
- me_t_sub_1  out  $clog2(DATA_WIDTH)  MSB index of d.
- me_ready  in  1  `mod_exp` idle.
- me_m  in  DATA_WIDTH  `mod_exp` result.
- me_done  in  1  one-cycle result strobe from `mod_exp`.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_m  out  DATA_WIDTH  result.
- rsp_err  out  1  job rejected; rsp_m = 0.

## Operation
- States: IDLE, R2, LAUNCH, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch c, d, n and register t_sub_1 = index of highest set bit of d. Next state:
  - n even, or n < 3, or c >= n -> RESP with rsp_err=1, rsp_m=0;
  - else d == 0 -> RESP with rsp_m=1, rsp_err=0 (`mod_exp` not run);
  - else -> R2 with x=1 and the iteration counter cleared.
- R2: exactly 2K iterations, one per enabled cycle: x2 = {x,1'b0} (DATA_WIDTH+1 bits); x = (x2 >= n) ? x2-n : x2. x < n holds throughout; no wider arithmetic is required. After the 2K-th iteration, r2_mod_n = x -> LAUNCH.
- LAUNCH: wait for me_ready=1; in the first such cycle, assert me_start for exactly one cycle -> WAIT.
- WAIT: on me_done, capture me_m into rsp_m -> RESP. me_done in any other state is ignored.
- RESP: rsp_valid=1; rsp_m and rsp_err are stable until rsp_valid && rsp_ready -> IDLE. Only one job is outstanding at a time.
- me_c, me_d, me_n, me_r2_mod_n and me_t_sub_1 are driven from registers. They are stable from entry into LAUNCH until WAIT exits.
- ce low: state, counter, x and all outputs freeze. A me_start pulse is never stretched or dropped: it is asserted only in the LAUNCH cycle with ce=1 and is gated by ce.

## Timing
- Reset (async, immediate): state IDLE; req_ready=1 after reset deasserts. me_start, rsp_valid, rsp_err = 0. rsp_m, all me_* operands, x and the counter = 0.
- Reset mid-job (any state): abort immediately and drop me_start the same instant. The job is lost and no response is produced.
- Latency, normal path with ce=1 throughout: acceptance edge T; R2 occupies T+1..T+2K (22 cycles at the default); me_start is high in cycle T+2K+1 if me_ready=1; rsp_valid rises the cycle after me_done.
- Latency, error and d==0 paths: rsp_valid is high in cycle T+1.
- req_ready=0 from the cycle after acceptance until the cycle after the rsp handshake completes. Back-to-back jobs are therefore separated by at least one IDLE cycle.
- rsp_ready may be held high before rsp_valid rises; the handshake then completes in the first RESP cycle.

## Test plan
- c=255, d=4, n=511 -> me_t_sub_1=2, me_r2_mod_n=16; a behavioural `mod_exp` returns 32 -> rsp_m=32, rsp_err=0; me_start is exactly one cycle, 23 cycles after acceptance.
- c=56, d=5, n=509 -> me_r2_mod_n=144, me_t_sub_1=2, rsp_m=393. Then c=56, d=1, n=509 -> t_sub_1=0, rsp_m=56. Then c=45, d=5, n=225 -> r2_mod_n=79, rsp_m=0.
- Rejects: n=510 -> rsp_err=1, rsp_m=0, one cycle after acceptance with no me_start. Repeat for c=300, n=299 and for n=1. Then d=0, n=509 -> rsp_m=1, rsp_err=0, no me_start.
- Backpressure and stalls: hold rsp_ready=0 for 10 cycles -> rsp_m/rsp_err stable and req_ready=0. Hold me_ready=0 for 5 cycles in LAUNCH -> me_start is delayed, not lost. Toggle ce low during R2 -> r2_mod_n is still correct and the latency stretches by the number of ce-low cycles.
- Assert rst in the middle of R2 and again in WAIT -> all outputs return to reset values immediately; a stray me_done afterwards is ignored; the next job completes correctly.
